gba_timer_array: RTL
====================

Name: gba_timer_array

Overview:
Parametrised GBA timer block: NUM_CH independent up-counters, each CNT_W bits wide. Each channel has a reload register, a per-channel prescaler, cascade (count-up) mode, an overflow strobe and an IRQ strobe. It sits behind the MMIO decoder and serves TMxCNT_L/H. It drives the interrupt controller and the sound FIFO overflow inputs.

Parameters:
NUM_CH, 4, number of timer channels (1..8)
CNT_W, 16, counter and reload width in bits (8..32)

Ports:
clock_16  input  1  system clock
reset  input  1  asynchronous reset, active-low (asserted when 0)
wr_en  input  1  register write strobe, one cycle
wr_ch  input  $clog2(NUM_CH) (min 1)  target channel of the write
wr_sel  input  1  0 = reload register, 1 = control register
wr_data  input  CNT_W  write data; control uses bits [7:0]
count  output  NUM_CH*CNT_W  live counter values; channel n at [n*CNT_W +: CNT_W]
ctrl  output  NUM_CH*8  control readback, same packing
overflow  output  NUM_CH  one-cycle pulse when a channel overflows
irq  output  NUM_CH  one-cycle pulse on overflow with IRQ enabled

Behaviour:
- Reset (reset==0, async): all counts, reload registers, control registers and prescaler counters go to 0. overflow and irq go to 0.
- Control bits: [1:0] prescale select (0:/1, 1:/64, 2:/256, 3:/1024), [2] cascade, [6] irq_en, [7] start. Bits [5:3] read back as written and have no function.
- wr_ch >= NUM_CH: the write is ignored.
- Reload write: updates the reload register only. It never changes count directly. It takes effect at the next start edge or overflow.
- Start edge: a control write changing start 0->1 loads count with the reload value and clears the channel prescaler on that clock edge.
  - The first increment can occur on the following cycle at the earliest.
  - In /1 mode, count = reload+1 one cycle after the load.
- Control write with start already 1: updates the other bits only, with no reload.
- Control write with start 1->0: count freezes at its current value and remains readable.
- Tick, non-cascade: per-channel 10-bit prescaler counter, active only while start==1. It wraps and produces a tick when it reaches divider-1 and then clears. /1 ticks every cycle. A prescale-select change while running clears the prescaler.
- Tick, cascade (channel n>0): the tick is overflow of channel n-1 in the same cycle (combinational chain). The prescaler is unused. Cascade on channel 0 is ignored and the channel uses its prescaler.
- On tick with start==1:
  - If count == all-ones: count <= reload, overflow[n] pulses for that cycle (registered, visible the next cycle), irq[n] pulses if irq_en.
  - Otherwise: count <= count+1.
- Cascade timing: an overflow chain through all channels resolves in one cycle. The overflow outputs of chained channels assert on the same cycle.
- Simultaneous reload write and overflow on the same channel: the overflow loads the newly written value (the write has priority into the reload path).
- Simultaneous start edge and tick on the same cycle: the start load wins and there is no increment.
- Reload = all-ones in /1 mode: overflow every cycle, and count stays at all-ones.
- Reset mid-count: all state clears immediately. Timers stay stopped until start is rewritten.

Test Plan:
1. Reset, write reload ch0=0xFFFC, ctrl ch0=0x80 (/1) -> count0 0xFFFC,FFFD,FFFE,FFFF,0xFFFC; overflow[0] pulses once per 4 cycles; irq[0] stays 0.
2. ch1 reload 0xFFFF, ctrl 0xC1 (/64, irq_en) -> count1 held 64 cycles, then overflow[1] and irq[1] pulse; reloads to 0xFFFF; period 64 cycles.
3. Cascade: ch0 reload 0xFFFF /1, ch1 reload 0xFFFE ctrl 0x84 -> ch1 increments once per cycle; on its overflow cycle, overflow[0] and overflow[1] both assert.
4. Running ch2 /1 from 0, write ctrl 0x00 at count 5 -> count2 holds 5. Rewrite 0x80 -> count2 reloads to 0, then 1.
5. Reload write on the exact overflow cycle of ch0 with value 0x1234 -> count0 = 0x1234 next cycle. Write to wr_ch=NUM_CH -> no register changes.
6. Assert reset=0 mid-count with irq pending -> count, ctrl, overflow and irq all 0 asynchronously. Run with CNT_W=8, NUM_CH=2: wrap at 0xFF.

Source files
------------

// File: rtl/gba_timer_array.sv
// GBA-style timer block: NUM_CH reloadable up-counters with per-channel prescaler,
// cascade chaining through the previous channel's overflow, and overflow/IRQ strobes.
module gba_timer_array #(
    parameter int  NUM_CH = 4,
    parameter int  CNT_W  = 16,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      clock_16,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic [CH_W-1:0]           wr_ch,
    input  logic                      wr_sel,
    input  logic [CNT_W-1:0]          wr_data,
    output logic [NUM_CH*CNT_W-1:0]   count,
    output logic [NUM_CH*8-1:0]       ctrl,
    output logic [NUM_CH-1:0]         overflow,
    output logic [NUM_CH-1:0]         irq
);

    logic [CNT_W-1:0] cnt_q [NUM_CH];
    logic [CNT_W-1:0] cnt_d [NUM_CH];
    logic [CNT_W-1:0] rel_q [NUM_CH];
    logic [CNT_W-1:0] rel_d [NUM_CH];
    logic [7:0]       ctl_q [NUM_CH];
    logic [7:0]       ctl_d [NUM_CH];
    logic [9:0]       psc_q [NUM_CH];
    logic [9:0]       psc_d [NUM_CH];
    logic [NUM_CH-1:0] ovf_q, ovf_d, irq_q, irq_d;

    // The cascade chain is walked channel by channel inside one process so the
    // overflow of channel n-1 feeds channel n in the same cycle.
    always_comb begin : next_state
        logic             carry;
        logic             hit;
        logic             ctl_wr;
        logic             run;
        logic             casc;
        logic             start_edge;
        logic             stop;
        logic             tick;
        logic             wrap;
        logic [9:0]       div_m1;
        logic [CNT_W-1:0] rel_next;

        // NOTE: every variable gets a default before any conditional write, so no latches are inferred.
        cnt_d      = cnt_q;
        rel_d      = rel_q;
        ctl_d      = ctl_q;
        psc_d      = psc_q;
        ovf_d      = '0;
        irq_d      = '0;
        carry      = 1'b0;
        hit        = 1'b0;
        ctl_wr     = 1'b0;
        run        = 1'b0;
        casc       = 1'b0;
        start_edge = 1'b0;
        stop       = 1'b0;
        tick       = 1'b0;
        wrap       = 1'b0;
        div_m1     = '0;
        rel_next   = '0;

        for (int n = 0; n < NUM_CH; n++) begin
            hit        = wr_en && (int'(wr_ch) == n);
            ctl_wr     = hit && wr_sel;
            run        = ctl_q[n][7];
            casc       = (n != 0) && ctl_q[n][2];
            start_edge = ctl_wr && wr_data[7] && !run;
            stop       = ctl_wr && !wr_data[7];

            case (ctl_q[n][1:0])
                2'd0:    div_m1 = 10'd0;
                2'd1:    div_m1 = 10'd63;
                2'd2:    div_m1 = 10'd255;
                default: div_m1 = 10'd1023;
            endcase

            tick     = casc ? carry : (run && (psc_q[n] == div_m1));
            rel_next = (hit && !wr_sel) ? wr_data : rel_q[n];
            wrap     = run && tick && !stop && (cnt_q[n] == '1);

            rel_d[n] = rel_next;
            if (ctl_wr)
                ctl_d[n] = wr_data[7:0];

            // A stop write freezes the count on the very edge it lands.
            if (start_edge)
                cnt_d[n] = rel_q[n];
            else if (run && tick && !stop)
                cnt_d[n] = wrap ? rel_next : cnt_q[n] + CNT_W'(1);

            if (start_edge || (ctl_wr && run && (wr_data[1:0] != ctl_q[n][1:0])))
                psc_d[n] = '0;
            else if (run && !casc)
                psc_d[n] = (psc_q[n] == div_m1) ? '0 : psc_q[n] + 10'd1;

            ovf_d[n] = wrap;
            irq_d[n] = wrap && ctl_q[n][6];
            carry    = wrap;
        end
    end

    always_ff @(posedge clock_16 or negedge reset) begin
        if (!reset) begin
            // NOTE: the register arrays are architectural state that software reads back, so they are reset.
            cnt_q <= '{default: '0};
            rel_q <= '{default: '0};
            ctl_q <= '{default: '0};
            psc_q <= '{default: '0};
            ovf_q <= '0;
            irq_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            cnt_q <= cnt_d;
            rel_q <= rel_d;
            ctl_q <= ctl_d;
            psc_q <= psc_d;
            ovf_q <= ovf_d;
            irq_q <= irq_d;
        end
    end

    always_comb begin
        count = '0;
        ctrl  = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            count[n*CNT_W +: CNT_W] = cnt_q[n];
            ctrl[n*8 +: 8]          = ctl_q[n];
        end
    end

    assign overflow = ovf_q;
    assign irq      = irq_q;

endmodule
